// File: rtl/axi_stream_upsizer.sv
// AXI4-Stream width upconverter: packs ratio narrow slave beats, little-endian by lane,
// into one wide master beat. A partial word is flushed early on TLAST or when TID/TDEST
// changes mid-word. The assembly register drives the master port directly.
module axi_stream_upsizer #(
  parameter int unsigned in_byte_width = 1,
  parameter int unsigned ratio         = 4,
  parameter int unsigned id_width      = 0,
  parameter int unsigned dest_width    = 0,
  parameter int unsigned user_width    = 0
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                s_tvalid,
  output logic                                                s_tready,
  input  logic [8*in_byte_width-1:0]                          s_tdata,
  input  logic [in_byte_width-1:0]                            s_tstrb,
  input  logic [in_byte_width-1:0]                            s_tkeep,
  input  logic                                                s_tlast,
  input  logic [(id_width > 0 ? id_width : 1)-1:0]            s_tid,
  input  logic [(dest_width > 0 ? dest_width : 1)-1:0]        s_tdest,
  input  logic [(user_width > 0 ? user_width : 1)-1:0]        s_tuser,
  output logic                                                m_tvalid,
  input  logic                                                m_tready,
  output logic [8*in_byte_width*ratio-1:0]                    m_tdata,
  output logic [in_byte_width*ratio-1:0]                      m_tstrb,
  output logic [in_byte_width*ratio-1:0]                      m_tkeep,
  output logic                                                m_tlast,
  output logic [(id_width > 0 ? id_width : 1)-1:0]            m_tid,
  output logic [(dest_width > 0 ? dest_width : 1)-1:0]        m_tdest,
  output logic [(user_width > 0 ? user_width * ratio : 1)-1:0] m_tuser
);

  localparam int unsigned DW  = 8 * in_byte_width;
  localparam int unsigned BW  = in_byte_width;
  localparam int unsigned IW  = (id_width > 0) ? id_width : 1;
  localparam int unsigned DSW = (dest_width > 0) ? dest_width : 1;
  localparam int unsigned UW  = (user_width > 0) ? user_width : 1;
  localparam int unsigned LW  = $clog2(ratio);

  logic [LW-1:0]       lane_q, lane_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [DW*ratio-1:0] data_q, data_d;
  logic [BW*ratio-1:0] strb_q, strb_d;
  logic [BW*ratio-1:0] keep_q, keep_d;
  logic [UW*ratio-1:0] user_q, user_d;
  logic [IW-1:0]       id_q, id_d;
  logic [DSW-1:0]      dest_q, dest_d;
  logic                rdy_q;

  logic out_free, id_diff, dest_diff, mismatch, accept, word_done;

  // Handshake qualifiers; ready is held low for one edge after reset release.
  always_comb begin
    out_free  = !valid_q || m_tready;
    id_diff   = (id_width > 0) && (s_tid != id_q);
    dest_diff = (dest_width > 0) && (s_tdest != dest_q);
    mismatch  = (lane_q != '0) && s_tvalid && (id_diff || dest_diff);
    s_tready  = rdy_q && !reset && out_free && !mismatch;
    accept    = s_tvalid && s_tready;
    word_done = (lane_q == LW'(ratio - 1)) || s_tlast;
  end

  // Next-state for lane counter, assembly register and master valid.
  always_comb begin
    lane_d  = lane_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    strb_d  = strb_q;
    keep_d  = keep_q;
    user_d  = user_q;
    id_d    = id_q;
    dest_d  = dest_q;
    if (valid_q && m_tready) valid_d = 1'b0;
    if (accept) begin
      // Lane 0 starts a fresh word so flushed partial words never carry stale lanes.
      if (lane_q == '0) begin
        data_d = '0;
        strb_d = '0;
        keep_d = '0;
        user_d = '0;
        id_d   = (id_width > 0) ? s_tid : '0;
        dest_d = (dest_width > 0) ? s_tdest : '0;
      end
      for (int k = 0; k < ratio; k++) begin
        if (lane_q == LW'(k)) begin
          data_d[k*DW +: DW] = s_tdata;
          strb_d[k*BW +: BW] = s_tstrb;
          keep_d[k*BW +: BW] = s_tkeep;
          user_d[k*UW +: UW] = (user_width > 0) ? s_tuser : '0;
        end
      end
      if (word_done) begin
        valid_d = 1'b1;
        last_d  = s_tlast;
        lane_d  = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end else if (mismatch && out_free) begin
      // Close the partial word; the held beat becomes lane 0 of the next one.
      valid_d = 1'b1;
      last_d  = 1'b0;
      lane_d  = '0;
    end
  end

  // State registers with asynchronous reset discarding any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      rdy_q   <= 1'b1;
    end
  end

  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tstrb  = strb_q;
  assign m_tkeep  = keep_q;
  assign m_tlast  = last_q;
  assign m_tid    = id_q;
  assign m_tdest  = dest_q;

  if (user_width > 0) begin : g_user
    assign m_tuser = user_q;
  end else begin : g_no_user
    assign m_tuser = 1'b0;
  end

endmodule

// File: tb/tb_axi_stream_upsizer.sv
// Scoreboard bench for axi_stream_upsizer (1-byte lanes, ratio 4, 2-bit TID).
module tb_axi_stream_upsizer;

  logic        clk;
  logic        reset;
  logic        s_tvalid, s_tready;
  logic [7:0]  s_tdata;
  logic        s_tstrb, s_tkeep, s_tlast;
  logic [1:0]  s_tid;
  logic        s_tdest, s_tuser;
  logic        m_tvalid, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb, m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic        m_tdest, m_tuser;

  axi_stream_upsizer #(
    .in_byte_width(1),
    .ratio        (4),
    .id_width     (2),
    .dest_width   (0),
    .user_width   (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tstrb (s_tstrb),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tid   (s_tid),
    .s_tdest (s_tdest),
    .s_tuser (s_tuser),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tstrb (m_tstrb),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tid   (m_tid),
    .m_tdest (m_tdest),
    .m_tuser (m_tuser)
  );

  // {data, keep, strb, last, id, dest, user}
  typedef logic [44:0] word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                          input logic l, input logic [1:0] id);
    exp_q.push_back({d, k, s, l, id, 1'b0, 1'b0});
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] id,
                      input logic k, output int stalls);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    s_tid    = id;
    s_tkeep  = k;
    s_tstrb  = k;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      if (stalls > 200) begin
        chk("send_timeout", 64'(stalls), 64'd0);
        s_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every master handshake, checks stability and backpressure during stalls.
  initial begin
    word_t got, snap;
    logic  prev_stall;
    prev_stall = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      got = {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser};
      if (prev_stall && m_tvalid) chk("stall_stable", 64'(got), 64'(snap));
      if (m_tvalid && !m_tready) begin
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        snap       = got;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'(got), 64'd0);
        else chk("word", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int st;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = 1'b0;
    s_tkeep  = 1'b0;
    s_tlast  = 1'b0;
    s_tid    = '0;
    s_tdest  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(s_tready), 64'd1);

    // Full word with TLAST on lane 3.
    push_exp(32'h44332211, 4'hF, 4'hF, 1'b1, 2'd0);
    send(8'h11, 1'b0, 2'd0, 1'b1, st);
    send(8'h22, 1'b0, 2'd0, 1'b1, st);
    send(8'h33, 1'b0, 2'd0, 1'b1, st);
    send(8'h44, 1'b1, 2'd0, 1'b1, st);
    chk("latency_valid", 64'(m_tvalid), 64'd1);
    idle();
    drain();

    // Early TLAST flush.
    push_exp(32'h0000BBAA, 4'h3, 4'h3, 1'b1, 2'd0);
    send(8'hAA, 1'b0, 2'd0, 1'b1, st);
    send(8'hBB, 1'b1, 2'd0, 1'b1, st);
    idle();
    drain();

    // TID change flushes a partial word and stalls the new beat one cycle.
    push_exp(32'h00000201, 4'h3, 4'h3, 1'b0, 2'd1);
    push_exp(32'h00000003, 4'h1, 4'h1, 1'b1, 2'd2);
    send(8'h01, 1'b0, 2'd1, 1'b1, st);
    send(8'h02, 1'b0, 2'd1, 1'b1, st);
    send(8'h03, 1'b1, 2'd2, 1'b1, st);
    chk("mismatch_stall", 64'(st), 64'd1);
    idle();
    drain();

    // 16 continuous beats with backpressure after the first word.
    push_exp(32'h04030201, 4'hF, 4'hF, 1'b0, 2'd0);
    push_exp(32'h08070605, 4'hF, 4'hF, 1'b0, 2'd0);
    push_exp(32'h0C0B0A09, 4'hF, 4'hF, 1'b0, 2'd0);
    push_exp(32'h100F0E0D, 4'hF, 4'hF, 1'b1, 2'd0);
    fork
      begin
        for (int i = 1; i <= 16; i++) send(8'(i), (i == 16), 2'd0, 1'b1, st);
        idle();
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk);
          #1;
          if (m_tvalid) break;
        end
        m_tready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-cycle discards a partial word.
    send(8'h55, 1'b0, 2'd0, 1'b1, st);
    send(8'h66, 1'b0, 2'd0, 1'b1, st);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("async_s_tready", 64'(s_tready), 64'd0);
    chk("async_m_tdata", 64'(m_tdata), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", 64'(s_tready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rerelease_ready", 64'(s_tready), 64'd1);

    // Clean word after reset; lane 1 carries keep=0 and must still occupy its lane.
    push_exp(32'h0D0C0B0A, 4'hD, 4'hD, 1'b1, 2'd3);
    send(8'h0A, 1'b0, 2'd3, 1'b1, st);
    send(8'h0B, 1'b0, 2'd3, 1'b0, st);
    send(8'h0C, 1'b0, 2'd3, 1'b1, st);
    send(8'h0D, 1'b1, 2'd3, 1'b1, st);
    idle();
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
